// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> FETCH.
//   Holds the fetched instruction for the ControlUnit, resolves the next PC
//   from branch/call/return strobes and ALU flags, and keeps return addresses
//   in an internal stack. A stack overflow or underflow parks the core in HALT
//   until reset.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   imem_req, imem_addr       fetch request (FETCH only) and its address (= pc)
//   imem_ready, instr_in      fetch accept and instruction word
//   instr, instr_valid        latched instruction, one-cycle pulse in DECODE
//   exec_done                 datapath finished; strobes/flags valid this cycle
//   b .. Ret                  ControlUnit branch/call/return strobes
//   flag_z/c/s/v              ALU flags
//   br_target, reg_target     immediate/relative target and register target
//   pc                        current program counter
//   stack_ovf, stack_unf      sticky stack fault flags
//   halted                    sequencer is in HALT
module pc_sequencer #(
    parameter int                 ADDR_W      = 32,
    parameter int                 STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       instr_in,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              b,
    input  logic              br,
    input  logic              bz,
    input  logic              bnz,
    input  logic              bcy,
    input  logic              bncy,
    input  logic              bs,
    input  logic              bns,
    input  logic              bv,
    input  logic              bnv,
    input  logic              Call,
    input  logic              Ret,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              flag_s,
    input  logic              flag_v,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_ovf,
    output logic              stack_unf,
    output logic              halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    // sp counts 0..STACK_DEPTH, so it needs one bit more than the entry index.
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [1:0]        state;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_dec;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_plus4;
    logic              cond_hit;
    logic              retire;
    logic              push_en;
    logic              sp_full;
    logic              sp_empty;

    always_comb begin
        pc_plus4 = pc + ADDR_W'(4);
        sp_dec   = sp - 1'b1;
        sp_full  = (sp == SP_FULL);
        sp_empty = (sp == '0);
        cond_hit = (bz   &  flag_z) | (bnz  & ~flag_z) |
                   (bcy  &  flag_c) | (bncy & ~flag_c) |
                   (bs   &  flag_s) | (bns  & ~flag_s) |
                   (bv   &  flag_v) | (bnv  & ~flag_v);
        retire   = (state == S_EXEC) && exec_done && !rst;
        // Ret outranks Call, so a Call only pushes when Ret is absent.
        push_en  = retire && !Ret && Call && !sp_full;
    end

    // Request/pulse outputs are suppressed combinationally while rst is held.
    assign imem_req    = (state == S_FETCH)  && !rst;
    assign instr_valid = (state == S_DECODE) && !rst;
    assign imem_addr   = pc;
    assign halted      = (state == S_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            sp        <= '0;
            instr     <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        instr <= instr_in;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (exec_done) begin
                        state <= S_FETCH;
                        if (Ret) begin
                            if (sp_empty) begin
                                stack_unf <= 1'b1;
                                state     <= S_HALT;
                            end else begin
                                pc <= stack_mem[sp_dec[IDX_W-1:0]];
                                sp <= sp_dec;
                            end
                        end else if (Call) begin
                            if (sp_full) begin
                                stack_ovf <= 1'b1;
                                state     <= S_HALT;
                            end else begin
                                pc <= br_target;
                                sp <= sp + 1'b1;
                            end
                        end else if (br) begin
                            pc <= reg_target;
                        end else if (b || cond_hit) begin
                            pc <= br_target;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                default: ; // HALT: frozen until reset
            endcase
        end
    end

    // Stack contents survive reset; only sp is cleared.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[sp[IDX_W-1:0]] <= pc_plus4;
        end
    end

endmodule
